// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: merges single-pixel writes with a rectangle-fill engine,
// round-robin while a fill is running, and drives registered RAM write signals.
module fb_write_arbiter #(
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 240,
    parameter int unsigned DATA_WIDTH = 16,
    localparam int unsigned XW        = $clog2(WIDTH),
    localparam int unsigned YW        = $clog2(HEIGHT)
) (
    input  logic                  wr_clk,
    input  logic                  rst,

    input  logic                  px_valid,
    output logic                  px_ready,
    input  logic [XW-1:0]         px_x,
    input  logic [YW-1:0]         px_y,
    input  logic [DATA_WIDTH-1:0] px_data,

    input  logic                  fill_valid,
    output logic                  fill_ready,
    input  logic [XW-1:0]         fill_x0,
    input  logic [XW-1:0]         fill_x1,
    input  logic [YW-1:0]         fill_y0,
    input  logic [YW-1:0]         fill_y1,
    input  logic [DATA_WIDTH-1:0] fill_color,
    output logic                  fill_busy,
    output logic                  fill_done,

    output logic                  wr_en,
    output logic [XW-1:0]         x_out,
    output logic [YW-1:0]         y_out,
    output logic [DATA_WIDTH-1:0] wr_out
);

    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e                state_q, state_d;
    logic                  last_px_q, last_px_d;
    logic [XW-1:0]         cx_q, cx_d;
    logic [YW-1:0]         cy_q, cy_d;
    logic [XW-1:0]         x0_q, x0_d;
    logic [XW-1:0]         x1_q, x1_d;
    logic [YW-1:0]         y1_q, y1_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;

    logic                  wr_en_q, wr_en_d;
    logic [XW-1:0]         x_out_q, x_out_d;
    logic [YW-1:0]         y_out_q, y_out_d;
    logic [DATA_WIDTH-1:0] wr_out_q, wr_out_d;
    logic                  fill_done_q, fill_done_d;

    logic                  px_in_range;
    logic [XW-1:0]         cmd_x1;
    logic [YW-1:0]         cmd_y1;
    logic                  cmd_degenerate;
    logic                  px_grant;
    logic                  fill_grant;

    always_comb begin
        px_in_range    = (px_x <= XMAX) && (px_y <= YMAX);
        cmd_x1         = (fill_x1 > XMAX) ? XMAX : fill_x1;
        cmd_y1         = (fill_y1 > YMAX) ? YMAX : fill_y1;
        cmd_degenerate = (fill_x0 > cmd_x1) || (fill_y0 > cmd_y1) ||
                         (fill_x0 > XMAX) || (fill_y0 > YMAX);
    end

    assign px_ready   = (state_q == StIdle) || !last_px_q;
    assign fill_ready = (state_q == StIdle);
    assign fill_busy  = (state_q == StFill);
    assign fill_done  = fill_done_q;
    assign wr_en      = wr_en_q;
    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign wr_out     = wr_out_q;

    always_comb begin
        state_d     = state_q;
        last_px_d   = last_px_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        color_d     = color_q;
        wr_en_d     = 1'b0;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        wr_out_d    = wr_out_q;
        fill_done_d = 1'b0;
        px_grant    = 1'b0;
        fill_grant  = 1'b0;

        unique case (state_q)
            StIdle: begin
                px_grant = px_valid;
                if (fill_valid) begin
                    x0_d    = fill_x0;
                    x1_d    = cmd_x1;
                    y1_d    = cmd_y1;
                    color_d = fill_color;
                    cx_d    = fill_x0;
                    cy_d    = fill_y0;
                    if (cmd_degenerate) begin
                        fill_done_d = 1'b1;
                    end else begin
                        state_d   = StFill;
                        // A same-cycle pixel takes this slot, so the fill owns the next one.
                        last_px_d = px_valid;
                    end
                end
            end
            StFill: begin
                if (px_valid && !last_px_q) begin
                    px_grant  = 1'b1;
                    last_px_d = 1'b1;
                end else begin
                    fill_grant = 1'b1;
                    last_px_d  = 1'b0;
                    if (cx_q == x1_q) begin
                        cx_d = x0_q;
                        cy_d = cy_q + 1'b1;
                        if (cy_q == y1_q) begin
                            state_d     = StIdle;
                            fill_done_d = 1'b1;
                        end
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Out-of-range pixels still consume their slot but never reach the RAM.
        if (px_grant && px_in_range) begin
            wr_en_d  = 1'b1;
            x_out_d  = px_x;
            y_out_d  = px_y;
            wr_out_d = px_data;
        end else if (fill_grant) begin
            wr_en_d  = 1'b1;
            x_out_d  = cx_q;
            y_out_d  = cy_q;
            wr_out_d = color_q;
        end
    end

    always_ff @(posedge wr_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            last_px_q   <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
            wr_en_q     <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            wr_out_q    <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_px_q   <= last_px_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            color_q     <= color_d;
            wr_en_q     <= wr_en_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            wr_out_q    <= wr_out_d;
            fill_done_q <= fill_done_d;
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: pixel path, fills, contention, clamping,
// degenerate commands and reset during a fill.
module tb_fb_write_arbiter;

    localparam int unsigned WIDTH      = 320;
    localparam int unsigned HEIGHT     = 240;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned XW         = 9;
    localparam int unsigned YW         = 8;

    logic                  wr_clk;
    logic                  rst;
    logic                  px_valid;
    logic                  px_ready;
    logic [XW-1:0]         px_x;
    logic [YW-1:0]         px_y;
    logic [DATA_WIDTH-1:0] px_data;
    logic                  fill_valid;
    logic                  fill_ready;
    logic [XW-1:0]         fill_x0;
    logic [XW-1:0]         fill_x1;
    logic [YW-1:0]         fill_y0;
    logic [YW-1:0]         fill_y1;
    logic [DATA_WIDTH-1:0] fill_color;
    logic                  fill_busy;
    logic                  fill_done;
    logic                  wr_en;
    logic [XW-1:0]         x_out;
    logic [YW-1:0]         y_out;
    logic [DATA_WIDTH-1:0] wr_out;

    int n_checks = 0;
    int n_errors = 0;

    fb_write_arbiter #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_data    (px_data),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_x0    (fill_x0),
        .fill_x1    (fill_x1),
        .fill_y0    (fill_y0),
        .fill_y1    (fill_y1),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .wr_en      (wr_en),
        .x_out      (x_out),
        .y_out      (y_out),
        .wr_out     (wr_out)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " wr_en"},      32'(wr_en),      32'(0));
        check({tag, " x_out"},      32'(x_out),      32'(0));
        check({tag, " y_out"},      32'(y_out),      32'(0));
        check({tag, " wr_out"},     32'(wr_out),     32'(0));
        check({tag, " fill_busy"},  32'(fill_busy),  32'(0));
        check({tag, " fill_done"},  32'(fill_done),  32'(0));
        check({tag, " px_ready"},   32'(px_ready),   32'(1));
        check({tag, " fill_ready"}, 32'(fill_ready), 32'(1));
    endtask

    task automatic check_write(input string tag, input int x, input int y, input int d,
                               input int done);
        check({tag, " wr_en"},     32'(wr_en),     32'(1));
        check({tag, " x_out"},     32'(x_out),     32'(x));
        check({tag, " y_out"},     32'(y_out),     32'(y));
        check({tag, " wr_out"},    32'(wr_out),    32'(d));
        check({tag, " fill_done"}, 32'(fill_done), 32'(done));
    endtask

    task automatic set_fill(input int x0, input int x1, input int y0, input int y1,
                            input int c);
        fill_valid = 1'b1;
        fill_x0    = XW'(x0);
        fill_x1    = XW'(x1);
        fill_y0    = YW'(y0);
        fill_y1    = YW'(y1);
        fill_color = DATA_WIDTH'(c);
    endtask

    initial begin
        rst        = 1'b0;
        px_valid   = 1'b0;
        px_x       = '0;
        px_y       = '0;
        px_data    = '0;
        fill_valid = 1'b0;
        fill_x0    = '0;
        fill_x1    = '0;
        fill_y0    = '0;
        fill_y1    = '0;
        fill_color = '0;

        #12;
        check_reset_outputs("reset");
        step();
        rst = 1'b1;
        step();

        // Single pixel
        px_valid = 1'b1;
        px_x     = XW'(5);
        px_y     = YW'(7);
        px_data  = 16'hF800;
        check("px idle ready", 32'(px_ready), 32'(1));
        step();
        px_valid = 1'b0;
        check_write("px write", 5, 7, 'hF800, 0);
        step();
        check("px one cycle", 32'(wr_en), 32'(0));

        // Basic fill (0,0)-(2,1)
        set_fill(0, 2, 0, 1, 'h07E0);
        step();
        fill_valid = 1'b0;
        check("fill busy", 32'(fill_busy), 32'(1));
        check("fill ready low", 32'(fill_ready), 32'(0));
        check("fill first latency", 32'(wr_en), 32'(0));
        for (int i = 0; i < 6; i++) begin
            step();
            check_write($sformatf("fill[%0d]", i), i % 3, i / 3, 'h07E0, (i == 5) ? 1 : 0);
        end
        step();
        check("fill end wr_en", 32'(wr_en), 32'(0));
        check("fill end ready", 32'(fill_ready), 32'(1));
        check("fill end busy", 32'(fill_busy), 32'(0));
        check("fill end done", 32'(fill_done), 32'(0));

        // Contention: pixel held high, accepted with the fill in the same cycle
        px_valid = 1'b1;
        px_x     = XW'(100);
        px_y     = YW'(50);
        px_data  = 16'h1234;
        set_fill(0, 2, 0, 1, 'h07E0);
        for (int k = 0; k < 12; k++) begin
            step();
            fill_valid = 1'b0;
            if (k % 2 == 0) begin
                check_write($sformatf("cont px[%0d]", k), 100, 50, 'h1234, 0);
            end else begin
                check_write($sformatf("cont fill[%0d]", k), ((k - 1) / 2) % 3,
                            ((k - 1) / 2) / 3, 'h07E0, (k == 11) ? 1 : 0);
            end
            check($sformatf("cont px_ready[%0d]", k), 32'(px_ready), 32'(k % 2));
        end
        px_valid = 1'b0;
        step();
        check("cont end wr_en", 32'(wr_en), 32'(0));
        check("cont end ready", 32'(fill_ready), 32'(1));

        // Clamping: (318,238)-(400,255) clips to the bottom-right 2x2
        set_fill(318, 400, 238, 255, 'h001F);
        step();
        fill_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_write($sformatf("clamp[%0d]", i), 318 + i % 2, 238 + i / 2, 'h001F,
                        (i == 3) ? 1 : 0);
        end
        step();
        check("clamp end wr_en", 32'(wr_en), 32'(0));
        check("clamp end busy", 32'(fill_busy), 32'(0));

        // Degenerate fill
        set_fill(10, 5, 0, 0, 'hFFFF);
        step();
        fill_valid = 1'b0;
        check("degen wr_en", 32'(wr_en), 32'(0));
        check("degen done", 32'(fill_done), 32'(1));
        check("degen busy", 32'(fill_busy), 32'(0));
        check("degen ready", 32'(fill_ready), 32'(1));
        step();
        check("degen done pulse", 32'(fill_done), 32'(0));
        check("degen no write", 32'(wr_en), 32'(0));

        // Out-of-range pixel
        px_valid = 1'b1;
        px_x     = XW'(320);
        px_y     = YW'(0);
        px_data  = 16'hAAAA;
        check("oor px ready", 32'(px_ready), 32'(1));
        step();
        px_valid = 1'b0;
        check("oor px wr_en", 32'(wr_en), 32'(0));
        step();
        check("oor px wr_en2", 32'(wr_en), 32'(0));

        // Reset during a 100-pixel fill
        set_fill(0, 99, 0, 0, 'h5555);
        step();
        fill_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_write($sformatf("rstfill[%0d]", i), i, 0, 'h5555, 0);
        end
        rst = 1'b0;
        #1;
        check_reset_outputs("midfill reset");
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset hold done[%0d]", i), 32'(fill_done), 32'(0));
        end
        rst = 1'b1;
        step();
        check_reset_outputs("after reset");
        set_fill(5, 5, 3, 3, 'hABCD);
        check("post reset fill ready", 32'(fill_ready), 32'(1));
        step();
        fill_valid = 1'b0;
        check("post reset busy", 32'(fill_busy), 32'(1));
        step();
        check_write("post reset fill", 5, 3, 'hABCD, 1);
        step();
        check("post reset idle", 32'(fill_busy), 32'(0));
        check("post reset no write", 32'(wr_en), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
